noc_credit_rx_port: RTL
=======================

// Module: noc_credit_rx_port
// PURPOSE
//  Router-side receive port for one PE injection link. Accepts 20-bit flits from the PE TX buffer,
//  stores them in a credit-protected FIFO and returns one credit pulse (co) per flit drained.
//  It pairs with the PE credit counter driven by ci, and presents flits plus a held route field
//  to the router switch.
// PARAMETERS
//  FLIT_W   20  flit width; [19:18]=type (00 idle, 01 head, 10 body, 11 tail), [17:14]=dest
//  DEPTH     8  FIFO entries; equals the PE credit count (counter limit 7 plus 1)
//  PTR_W     3  log2(DEPTH)
// PORTS
//  clk           in   1       system clock, rising edge
//  rst           in   1       asynchronous, active-low reset
//  datain        in   FLIT_W  flit from PE TX buffer
//  in_valid      in   1       datain valid this cycle
//  co            out  1       credit return; one-cycle pulse per flit popped
//  dataout       out  FLIT_W  FIFO head flit to switch
//  out_valid     out  1       dataout valid
//  out_ready     in   1       switch grant; pop when out_valid && out_ready
//  route_dest    out  4       dest of the current packet; held from head until tail pops
//  route_valid   out  1       route_dest valid
//  err_overflow  out  1       sticky overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: FIFO empty, pointers 0, count 0. co, out_valid, route_valid, err_overflow = 0.
//    dataout and route_dest = 0. Reset mid-packet discards all content and returns no credits.
//  - Push when in_valid && datain[19:18]!=00 && count<DEPTH. Idle-type flits are ignored.
//  - Pop when out_valid && out_ready. out_valid = (count!=0). dataout = mem[rd_ptr], from a registered FIFO.
//  - Latency: a flit pushed at edge N is visible on dataout after edge N, so it is poppable in cycle N+1.
//  - co is registered: pop at edge N -> co=1 for the cycle after edge N. Back-to-back pops give continuous co.
//  - Simultaneous push and pop: count unchanged. This is allowed at full and at empty;
//    at empty, pop requires out_valid so only the push occurs.
//  - Pointers wrap modulo DEPTH; count is PTR_W+1 bits, range 0..DEPTH.
//  - Push at count==DEPTH without a same-cycle pop is an overflow, i.e. a credit protocol violation.
//    The flit is dropped and FIFO state is unchanged.
//  - Packet FSM on the popped stream:
//      IDLE -> HEAD_WAIT when the FIFO head is type 01 (head). In HEAD_WAIT:
//        route_dest = head[17:14], route_valid = 1.
//      HEAD_WAIT -> ACTIVE when the head is popped.
//      ACTIVE -> IDLE when a tail (11) is popped. route_valid drops the cycle after the tail pop.
//      Body (10) or tail at the FIFO head while IDLE is a framing error: the flit is popped and credited,
//        no route is issued, and the FSM stays in IDLE.
//      Head at the FIFO head while ACTIVE closes the current packet and goes to HEAD_WAIT with the new dest.
// CONFIGURATION
//  INBUF_OVERFLOW_CHK_EN defined:
//    overflow or framing error sets err_overflow=1, sticky until reset.
//  INBUF_OVERFLOW_CHK_EN undefined:
//    err_overflow tied 0 and the detection logic is removed. Overflowing flits are still dropped.
// STRUCTURE
//  - Shared package noc_pkg: FLIT_W, flit type codes (FT_IDLE/HEAD/BODY/TAIL), DEST_MSB/LSB, default DEPTH.
//  - One sub-module: noc_sync_fifo (DEPTH x FLIT_W; push/pop/full/empty/count).
//  - Credit pulse and packet FSM live in the top module.
// TESTING
//  1. Reset: rst=0 with in_valid=1 -> all outputs 0; after release count=0 and co stays 0.
//  2. Single packet: push head dest=4'h5, body, tail; out_ready=1 ->
//       dataout in order, route_dest=5 from head until tail pop;
//       exactly 3 co pulses, each 1 cycle after its pop.
//  3. Fill: out_ready=0, push 8 flits -> count=8;
//       9th push dropped and err_overflow=1 (macro on) or 0 (macro off);
//       no co pulses while out_ready=0.
//  4. Full with push and pop in the same cycle: count stays 8, no overflow, one co pulse,
//       and the new flit exits 8th after wrap.
//  5. Framing: body flit arrives first -> popped, 1 co, route_valid=0, err_overflow=1 with macro on.
//  6. Reset mid-packet after 3 pushes -> FIFO empty, FSM IDLE, route_valid=0, no co.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit type codes and default receive buffer depth.
package noc_pkg;

  localparam int unsigned FLIT_W    = 20;
  localparam int unsigned TYPE_MSB  = 19;
  localparam int unsigned TYPE_LSB  = 18;
  localparam int unsigned DEST_MSB  = 17;
  localparam int unsigned DEST_LSB  = 14;
  localparam int unsigned DEST_W    = DEST_MSB - DEST_LSB + 1;
  localparam int unsigned PAYLOAD_W = FLIT_W - 2 - DEST_W;
  localparam int unsigned NOC_DEPTH = 8;
  localparam int unsigned NOC_PTR_W = $clog2(NOC_DEPTH);

  typedef enum logic [1:0] {
    FT_IDLE = 2'b00,
    FT_HEAD = 2'b01,
    FT_BODY = 2'b10,
    FT_TAIL = 2'b11
  } flit_type_e;

  typedef struct packed {
    flit_type_e             ftype;
    logic [DEST_W-1:0]      dest;
    logic [PAYLOAD_W-1:0]   payload;
  } flit_t;

  typedef enum logic [1:0] {
    PKT_IDLE      = 2'b00,
    PKT_HEAD_WAIT = 2'b01,
    PKT_ACTIVE    = 2'b10
  } pkt_state_e;

  function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] f);
    return flit_type_e'(f[TYPE_MSB:TYPE_LSB]);
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Flop-based synchronous FIFO; head entry is readable combinationally, push at full is
// accepted only when a pop frees the slot in the same cycle.
module noc_sync_fifo
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = NOC_DEPTH,
  parameter int unsigned WIDTH = FLIT_W
)
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata_c,
  output logic                         full_c,
  output logic                         empty_c,
  output logic                         overflow_c,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full_c     = (count == CNT_W'(DEPTH));
  assign empty_c    = (count == '0);
  assign pop_ok     = pop && !empty_c;
  assign push_ok    = push && (!full_c || pop_ok);
  assign overflow_c = push && full_c && !pop_ok;
  assign rdata_c    = mem[rd_ptr];

  // Storage, pointers and occupancy; an overflowing push leaves all of them untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_credit_rx_port.sv
// Router receive port for a PE injection link: credit-protected flit FIFO, credit return
// pulse and packet route tracking. Define INBUF_OVERFLOW_CHK_EN to enable err_overflow.
module noc_credit_rx_port
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = NOC_DEPTH
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] datain,
  input  logic              in_valid,
  output logic              co,
  output logic [FLIT_W-1:0] dataout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DEST_W-1:0] route_dest,
  output logic              route_valid,
  output logic              err_overflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_overflow;
  logic [CNT_W-1:0] fifo_count;

  pkt_state_e        state_q;
  pkt_state_e        state_d;
  logic [DEST_W-1:0] route_dest_d;
  logic              framing_err;
  flit_type_e        head_type;

  assign fifo_push = in_valid && (flit_type(datain) != FT_IDLE);
  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  assign head_type = flit_type(dataout);

  noc_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .wdata      (datain),
    .pop        (fifo_pop),
    .rdata_c    (dataout),
    .full_c     (fifo_full),
    .empty_c    (fifo_empty),
    .overflow_c (fifo_overflow),
    .count      (fifo_count)
  );

  logic unused_fifo;
  assign unused_fifo = ^{fifo_full, fifo_count};

  // Packet tracking on the FIFO head; a head flit always (re)opens a route, even mid-packet.
  always_comb begin
    state_d      = state_q;
    route_dest_d = route_dest;
    framing_err  = 1'b0;
    if (!fifo_empty) begin
      if (head_type == FT_HEAD) begin
        route_dest_d = dataout[DEST_MSB:DEST_LSB];
        state_d      = fifo_pop ? PKT_ACTIVE : PKT_HEAD_WAIT;
      end else if (fifo_pop) begin
        case (state_q)
          PKT_ACTIVE: begin
            if (head_type == FT_TAIL) state_d = PKT_IDLE;
          end
          default: begin
            framing_err = 1'b1;
            state_d     = PKT_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PKT_IDLE;
      route_dest  <= '0;
      route_valid <= 1'b0;
      co          <= 1'b0;
    end else begin
      state_q     <= state_d;
      route_dest  <= route_dest_d;
      route_valid <= (state_d != PKT_IDLE);
      co          <= fifo_pop;
    end
  end

`ifdef INBUF_OVERFLOW_CHK_EN
  // Sticky protocol error: credit overflow or body/tail without an open packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_overflow <= 1'b0;
    end else if (fifo_overflow || framing_err) begin
      err_overflow <= 1'b1;
    end
  end
`else
  assign err_overflow = 1'b0;
  logic unused_err;
  assign unused_err = ^{fifo_overflow, framing_err};
`endif

endmodule
